// File: rtl/lsu_multi_issue_controller.sv
// Matrix LSU issue queue: buffers dispatched instructions in a circular FIFO and issues the head
// to one of N_UNITS register loaders by round-robin, snapshotting the CSR configuration.

package matrix_cps_pkg;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [4:0]  mreg;
    logic [22:0] addr;
  } lsu_instr_t;

  typedef struct packed {
    logic [7:0]  rows;
    logic [7:0]  cols;
    logic [15:0] stride;
  } lsu_conf_t;

endpackage

module lsu_multi_issue_controller #(
  parameter int unsigned N_SLOTS     = 4,
  parameter int unsigned N_UNITS     = 2,
  parameter int unsigned FULL_MARGIN = 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      flush_i,
  output logic                                      issue_queue_full_o,
  input  logic                                      dispatch_i,
  input  matrix_cps_pkg::lsu_instr_t                dispatched_instr_i,
  input  matrix_cps_pkg::lsu_conf_t                 csr_config_i,
  input  logic [N_UNITS-1:0]                        busy_i,
  output logic [N_UNITS-1:0]                        start_o,
  output matrix_cps_pkg::lsu_instr_t [N_UNITS-1:0]  issued_instr_o,
  output matrix_cps_pkg::lsu_conf_t  [N_UNITS-1:0]  issued_instr_conf_o,
  output logic [$clog2(N_SLOTS+1)-1:0]              occupancy_o,
  output logic                                      overflow_o,
  output logic                                      idle_o
);

  localparam int unsigned PtrW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned CntW = $clog2(N_SLOTS + 1);
  localparam int unsigned RrW  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  localparam logic [PtrW-1:0] LastSlot  = PtrW'(N_SLOTS - 1);
  localparam logic [RrW-1:0]  LastUnit  = RrW'(N_UNITS - 1);
  localparam logic [CntW-1:0] FullCount = CntW'(N_SLOTS);
  localparam logic [CntW-1:0] FullThr   = CntW'(N_SLOTS - FULL_MARGIN);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [RrW-1:0]  rr_q, rr_d;
  logic [N_UNITS-1:0] start_q, start_d;
  logic            overflow_q, overflow_d;

  matrix_cps_pkg::lsu_instr_t [N_UNITS-1:0] issued_q, issued_d;
  matrix_cps_pkg::lsu_conf_t  [N_UNITS-1:0] conf_q, conf_d;

  matrix_cps_pkg::lsu_instr_t mem_q [N_SLOTS];

  logic [N_UNITS-1:0] eligible;
  logic [RrW-1:0]     scan_idx;
  logic [RrW-1:0]     sel_idx;
  logic               sel_valid;
  logic               slots_full;
  logic               push;
  logic               pop;

  // A unit that was just started has not raised busy yet, so mask it for that cycle.
  assign eligible = ~busy_i & ~start_q;

  always_comb begin
    scan_idx  = '0;
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < int'(N_UNITS); k++) begin
      scan_idx = RrW'((int'(rr_q) + k) % int'(N_UNITS));
      if (!sel_valid && eligible[scan_idx]) begin
        sel_valid = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign slots_full = (count_q == FullCount);
  assign pop        = (count_q != '0) && !flush_i && sel_valid;
  assign push       = dispatch_i && !flush_i && (!slots_full || pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rr_d       = rr_q;
    start_d    = '0;
    issued_d   = issued_q;
    conf_d     = conf_q;
    overflow_d = overflow_q | (dispatch_i && !flush_i && slots_full && !pop);

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      rr_d     = '0;
    end else begin
      if (pop) begin
        issued_d[sel_idx] = mem_q[rd_ptr_q];
        conf_d[sel_idx]   = csr_config_i;
        start_d[sel_idx]  = 1'b1;
        rd_ptr_d          = (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + PtrW'(1);
        rr_d              = (sel_idx == LastUnit) ? '0 : sel_idx + RrW'(1);
      end
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rr_q       <= '0;
      start_q    <= '0;
      issued_q   <= '0;
      conf_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      start_q    <= start_d;
      issued_q   <= issued_d;
      conf_q     <= conf_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dispatched_instr_i;
    end
  end

  assign issue_queue_full_o  = (count_q >= FullThr);
  assign start_o             = start_q;
  assign issued_instr_o      = issued_q;
  assign issued_instr_conf_o = conf_q;
  assign occupancy_o         = count_q;
  assign overflow_o          = overflow_q;
  assign idle_o              = (count_q == '0) && !(|busy_i) && !(|start_q);

endmodule

// File: tb/tb_lsu_multi_issue_controller.sv
// Self-checking bench for lsu_multi_issue_controller: queue-based reference model compared every
// cycle, plus hand-computed expectations for the directed scenarios.

module tb_lsu_multi_issue_controller;
  import matrix_cps_pkg::*;

  localparam int unsigned N_SLOTS     = 4;
  localparam int unsigned N_UNITS     = 2;
  localparam int unsigned FULL_MARGIN = 1;
  localparam int unsigned CntW        = $clog2(N_SLOTS + 1);

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 dispatch;
  lsu_instr_t           instr;
  lsu_conf_t            csr;
  logic [N_UNITS-1:0]   busy;
  logic                 full_o;
  logic [N_UNITS-1:0]   start_o;
  lsu_instr_t [N_UNITS-1:0] iss_o;
  lsu_conf_t  [N_UNITS-1:0] conf_o;
  logic [CntW-1:0]      occ_o;
  logic                 ovf_o;
  logic                 idle_o;

  int n_chk  = 0;
  int n_fail = 0;

  lsu_multi_issue_controller #(
    .N_SLOTS    (N_SLOTS),
    .N_UNITS    (N_UNITS),
    .FULL_MARGIN(FULL_MARGIN)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .flush_i            (flush),
    .issue_queue_full_o (full_o),
    .dispatch_i         (dispatch),
    .dispatched_instr_i (instr),
    .csr_config_i       (csr),
    .busy_i             (busy),
    .start_o            (start_o),
    .issued_instr_o     (iss_o),
    .issued_instr_conf_o(conf_o),
    .occupancy_o        (occ_o),
    .overflow_o         (ovf_o),
    .idle_o             (idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending instructions and per-unit output state.
  lsu_instr_t         q[$];
  logic [N_UNITS-1:0] m_start;
  lsu_instr_t         m_iss [N_UNITS];
  lsu_conf_t          m_conf[N_UNITS];
  int                 m_rr;
  logic               m_ovf;

  task automatic model_reset();
    q.delete();
    m_start = '0;
    for (int u = 0; u < int'(N_UNITS); u++) begin
      m_iss[u]  = '0;
      m_conf[u] = '0;
    end
    m_rr  = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    int sel;
    bit can_pop;
    sel = -1;
    for (int k = 0; k < int'(N_UNITS); k++) begin
      int u;
      u = (m_rr + k) % int'(N_UNITS);
      if (sel < 0 && !busy[u] && !m_start[u]) sel = u;
    end
    can_pop = (q.size() > 0) && !flush && (sel >= 0);
    m_start = '0;
    if (flush) begin
      q.delete();
      m_rr = 0;
    end else begin
      if (dispatch && q.size() == int'(N_SLOTS) && !can_pop) m_ovf = 1'b1;
      if (can_pop) begin
        m_iss[sel]   = q.pop_front();
        m_conf[sel]  = csr;
        m_start[sel] = 1'b1;
        m_rr         = (sel + 1) % int'(N_UNITS);
      end
      if (dispatch && q.size() < int'(N_SLOTS)) q.push_back(instr);
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    chk("start", 64'(start_o), 64'(m_start));
    for (int u = 0; u < int'(N_UNITS); u++) begin
      chk($sformatf("issued[%0d]", u), 64'(iss_o[u]), 64'(m_iss[u]));
      chk($sformatf("conf[%0d]", u), 64'(conf_o[u]), 64'(m_conf[u]));
    end
    chk("occupancy", 64'(occ_o), 64'(q.size()));
    chk("overflow", 64'(ovf_o), 64'(m_ovf));
    chk("idle", 64'(idle_o), 64'((q.size() == 0) && (busy == '0) && (m_start == '0)));
    chk("full", 64'(full_o), 64'(q.size() >= int'(N_SLOTS - FULL_MARGIN)));
  end

  task automatic cyc(input logic d, input lsu_instr_t ins, input logic [N_UNITS-1:0] b,
                     input logic f, input lsu_conf_t c);
    @(posedge clk);
    #2;
    dispatch = d;
    instr    = ins;
    busy     = b;
    flush    = f;
    csr      = c;
  endtask

  localparam lsu_instr_t IA = 32'hA000_0001;
  localparam lsu_instr_t IB = 32'hB000_0002;
  localparam lsu_instr_t IC = 32'hC000_0003;
  localparam lsu_instr_t IE1 = 32'h1100_0011;
  localparam lsu_instr_t IE2 = 32'h1200_0012;
  localparam lsu_instr_t IE3 = 32'h1300_0013;
  localparam lsu_instr_t IE4 = 32'h1400_0014;
  localparam lsu_instr_t IE5 = 32'h1500_0015;
  localparam lsu_instr_t IF  = 32'hF000_00FF;
  localparam lsu_instr_t IG  = 32'h6000_0066;
  localparam lsu_instr_t IH  = 32'h7000_0077;
  localparam lsu_instr_t IJ  = 32'h8000_0088;
  localparam lsu_instr_t IK  = 32'h9000_0099;
  localparam lsu_instr_t IL  = 32'hD000_00DD;
  localparam lsu_instr_t IM  = 32'hE000_00EE;
  localparam lsu_conf_t  CX  = 32'h0404_0010;
  localparam lsu_conf_t  CY  = 32'h0808_0020;
  localparam lsu_conf_t  CZ  = 32'h1010_0040;

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    dispatch = 1'b0;
    instr    = '0;
    csr      = CX;
    busy     = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_start", 64'(start_o), 64'(0));
    chk("rst_idle", 64'(idle_o), 64'(1));
    rst_n = 1'b1;

    // Round-robin across free loaders
    cyc(1'b1, IA, 2'b00, 1'b0, CX);
    cyc(1'b1, IB, 2'b00, 1'b0, CX);
    cyc(1'b1, IC, 2'b00, 1'b0, CX);
    chk("rr_a_start", 64'(start_o), 64'(2'b01));
    chk("rr_a_instr", 64'(iss_o[0]), 64'(IA));
    cyc(1'b0, '0, 2'b00, 1'b0, CX);
    chk("rr_b_start", 64'(start_o), 64'(2'b10));
    chk("rr_b_instr", 64'(iss_o[1]), 64'(IB));
    cyc(1'b0, '0, 2'b00, 1'b0, CX);
    chk("rr_c_start", 64'(start_o), 64'(2'b01));
    chk("rr_c_instr", 64'(iss_o[0]), 64'(IC));
    cyc(1'b0, '0, 2'b00, 1'b0, CX);
    chk("rr_idle", 64'(idle_o), 64'(1));

    // Fill with all units busy, early full and overflow
    cyc(1'b1, IE1, 2'b11, 1'b0, CX);
    cyc(1'b1, IE2, 2'b11, 1'b0, CX);
    cyc(1'b1, IE3, 2'b11, 1'b0, CX);
    chk("full_at2", 64'(full_o), 64'(0));
    cyc(1'b1, IE4, 2'b11, 1'b0, CX);
    chk("full_at3", 64'(full_o), 64'(1));
    chk("occ_3", 64'(occ_o), 64'(3));
    cyc(1'b1, IE5, 2'b11, 1'b0, CX);
    cyc(1'b0, '0, 2'b11, 1'b0, CX);
    chk("ovf_occ", 64'(occ_o), 64'(4));
    chk("ovf_flag", 64'(ovf_o), 64'(1));

    // Push and pop together while full
    cyc(1'b1, IF, 2'b10, 1'b0, CX);
    cyc(1'b0, '0, 2'b10, 1'b0, CX);
    chk("pp_start", 64'(start_o), 64'(2'b01));
    chk("pp_instr", 64'(iss_o[0]), 64'(IE1));
    chk("pp_occ", 64'(occ_o), 64'(4));
    cyc(1'b0, '0, 2'b11, 1'b0, CX);
    chk("pp_mask", 64'(start_o), 64'(0));

    // Configuration captured in the pop cycle
    cyc(1'b0, '0, 2'b10, 1'b0, CY);
    cyc(1'b0, '0, 2'b11, 1'b0, CZ);
    chk("csr_instr", 64'(iss_o[0]), 64'(IE2));
    chk("csr_snap", 64'(conf_o[0]), 64'(CY));
    cyc(1'b0, '0, 2'b11, 1'b0, CZ);
    chk("csr_hold", 64'(conf_o[0]), 64'(CY));
    chk("csr_occ", 64'(occ_o), 64'(3));

    // Flush with dispatch and free units
    cyc(1'b1, IG, 2'b00, 1'b1, CX);
    cyc(1'b0, '0, 2'b00, 1'b0, CX);
    chk("fl_start", 64'(start_o), 64'(0));
    chk("fl_occ", 64'(occ_o), 64'(0));
    chk("fl_ovf", 64'(ovf_o), 64'(1));
    cyc(1'b1, IH, 2'b00, 1'b0, CX);
    cyc(1'b0, '0, 2'b00, 1'b0, CX);
    cyc(1'b0, '0, 2'b00, 1'b0, CX);
    chk("fl_rr_start", 64'(start_o), 64'(2'b01));
    chk("fl_rr_instr", 64'(iss_o[0]), 64'(IH));
    cyc(1'b0, '0, 2'b00, 1'b0, CX);

    // Asynchronous reset mid-stream
    cyc(1'b1, IJ, 2'b11, 1'b0, CX);
    cyc(1'b1, IK, 2'b11, 1'b0, CX);
    cyc(1'b1, IL, 2'b11, 1'b0, CX);
    cyc(1'b0, '0, 2'b01, 1'b0, CX);
    cyc(1'b0, '0, 2'b11, 1'b0, CX);
    chk("ar_pre_start", 64'(start_o), 64'(2'b10));
    chk("ar_pre_occ", 64'(occ_o), 64'(2));
    busy = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_start", 64'(start_o), 64'(0));
    chk("ar_occ", 64'(occ_o), 64'(0));
    chk("ar_ovf", 64'(ovf_o), 64'(0));
    chk("ar_idle", 64'(idle_o), 64'(1));
    chk("ar_instr", 64'(iss_o[1]), 64'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, '0, 2'b00, 1'b0, CX);
    chk("ar_quiet", 64'(start_o), 64'(0));
    cyc(1'b1, IM, 2'b00, 1'b0, CX);
    cyc(1'b0, '0, 2'b00, 1'b0, CX);
    cyc(1'b0, '0, 2'b00, 1'b0, CX);
    chk("ar_new_start", 64'(start_o), 64'(2'b01));
    chk("ar_new_instr", 64'(iss_o[0]), 64'(IM));
    repeat (3) cyc(1'b0, '0, 2'b00, 1'b0, CX);

    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_multi_issue_controller.md
Name: lsu_multi_issue_controller

Overview:
- Parametrised issue queue plus dispatcher for the matrix LSU. Feeds N_UNITS independent register loaders instead of a single one.
- Buffers dispatched lsu_instr_t entries in an N_SLOTS FIFO and issues the head to a free loader using round-robin selection.
- Snapshots the CSR configuration at issue time.
- Adds flush, an early-full margin, occupancy reporting, an overflow error flag and an idle indication.

Parameters:
N_SLOTS, 4, FIFO depth in instructions (>=2)
N_UNITS, 2, number of register loaders served (>=1)
FULL_MARGIN, 1, issue_queue_full_o asserts when occupancy >= N_SLOTS-FULL_MARGIN (0..N_SLOTS-1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  discard all queued instructions
issue_queue_full_o  out  1  back-pressure to dispatcher (early full)
dispatch_i  in  1  push dispatched_instr_i this cycle
dispatched_instr_i  in  matrix_cps_pkg::lsu_instr_t  instruction to enqueue
csr_config_i  in  matrix_cps_pkg::lsu_conf_t  current matrix CSR configuration
busy_i  in  N_UNITS  per-loader busy
start_o  out  N_UNITS  per-loader one-cycle start pulse
issued_instr_o  out  N_UNITS x lsu_instr_t  per-loader issued instruction (registered)
issued_instr_conf_o  out  N_UNITS x lsu_conf_t  per-loader configuration snapshot (registered)
occupancy_o  out  $clog2(N_SLOTS+1)  current FIFO entry count
overflow_o  out  1  sticky: push attempted while truly full
idle_o  out  1  queue empty, no loader busy, no start pending

Behaviour:
- Reset (async, rst_ni=0) sets:
  - start_o=0, all issued_instr_o/issued_instr_conf_o='0
  - occupancy_o=0, overflow_o=0, idle_o=1
  - read/write pointers=0, round-robin pointer rr=0
  - A reset mid-operation drops all queued entries immediately.
- FIFO:
  - Circular buffer, N_SLOTS entries; pointers wrap modulo N_SLOTS (non-power-of-2 depths supported).
  - No fall-through: an entry pushed in cycle t is issuable at t+1 at the earliest.
- Push:
  - Occurs when dispatch_i && !flush_i && (count<N_SLOTS || pop this cycle).
  - dispatch_i with count==N_SLOTS and no pop: entry dropped, overflow_o<=1 (sticky until reset).
- Early full: issue_queue_full_o = (count >= N_SLOTS-FULL_MARGIN), combinational from count.
- Unit eligibility: eligible[u] = !busy_i[u] && !start_o[u]. This masks the one-cycle gap before the loader raises busy.
- Issue (at most one per cycle):
  - Condition: count>0 && !flush_i && any eligible.
  - Selected unit: first eligible scanning u = rr, rr+1, ... modulo N_UNITS.
  - Next edge: issued_instr_o[u]<=head, issued_instr_conf_o[u]<=csr_config_i (value in the pop cycle), start_o[u]<=1, pop head, rr<=(u+1) mod N_UNITS.
  - All other start_o bits are 0; start_o is one-hot or zero and lasts one cycle.
  - Latency: a head entry with a free unit gives start_o one cycle after the pop decision, two cycles after the push at minimum.
- Simultaneous push and pop: count unchanged; allowed at count==N_SLOTS (the freed slot is reused).
- Flush: at next edge pointers=0, count=0, rr=0; no push and no issue in the flush cycle.
  - Output registers keep their previous values.
  - A start_o already asserted in the flush cycle still clears normally next cycle.
  - overflow_o is unaffected.
- idle_o = (count==0) && !(|busy_i) && !(|start_o), combinational.
- Count arithmetic: count = count + push - pop; never exceeds N_SLOTS, never underflows (pop needs count>0).

Test Plan:
- Reset, then push A,B,C on consecutive cycles with busy_i=00 -> start_o=01 with A; next cycle start_o=10 with B; then start_o=01 with C. Round-robin alternates; occupancy returns to 0; idle_o=1 once start_o=0.
- N_SLOTS=4, FULL_MARGIN=1, busy_i=11, push 4 entries -> issue_queue_full_o rises when occupancy=3. Fifth push with no pop -> entry dropped, overflow_o=1, occupancy_o=4.
- Full queue (4), busy_i=10, dispatch_i=1 in the same cycle as a pop -> both accepted; occupancy stays 4; start_o[0] pulses once, then unit 0 is masked for one cycle.
- csr_config_i changes from X to Y on the pop cycle of entry D -> issued_instr_conf_o for D equals Y. A later change does not alter the registered value.
- Occupancy 3, flush_i=1 with dispatch_i=1 and a unit free -> no start_o next cycle, occupancy_o=0, rr=0. The next push issues to unit 0.
- Assert rst_ni=0 mid-stream with occupancy 2 and start_o=10 -> all outputs return to reset values immediately (asynchronously); no start_o after release until a new push.
